probatina_kernel_ctrl: RTL and testbench

Parametrised multi-channel kernel control sequencer that replaces the single-channel ap_start/ap_done glue in the kernel top level. It converts the host ap_start level into per-channel start pulses, aggregates done from up to C_NUM_CH vadd-style channel engines, and drives ap_idle/ap_done/ap_ready. It supports both ap_ctrl_hs and ap_ctrl_chain protocols, a runtime channel-enable mask, and a saturating run-cycle performance counter.

---
 rtl/probatina_ctrl_pkg.sv | 18 +
 rtl/probatina_sat_counter.sv | 52 +++++
 rtl/probatina_kernel_ctrl.sv | 149 ++++++++++++++
 tb/tb_probatina_kernel_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/probatina_ctrl_pkg.sv
// Shared definitions for the multi-channel kernel control sequencer.
// Contents:
//   ctrl_state_e    - sequencer FSM state encoding (IDLE, LAUNCH, RUN, DONE)
//   CTRL_MODE_HS    - C_CHAIN_MODE value for ap_ctrl_hs (ap_done is a one-cycle pulse)
//   CTRL_MODE_CHAIN - C_CHAIN_MODE value for ap_ctrl_chain (ap_done held until ap_continue)
package probatina_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } ctrl_state_e;

    localparam int unsigned CTRL_MODE_HS    = 32'd0;
    localparam int unsigned CTRL_MODE_CHAIN = 32'd1;

endpackage

// File: rtl/probatina_sat_counter.sv
// Saturating up-counter used to measure run length.
// Ports:
//   ap_clk     in  clock
//   areset     in  synchronous active-high reset (count -> 0)
//   clr        in  clear to zero (has priority over en)
//   en         in  increment enable; holds at all-ones instead of wrapping
//   count      out current count
//   count_next out value the counter takes at the next edge
module probatina_sat_counter
    import probatina_ctrl_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         ap_clk,
    input  logic         areset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/probatina_kernel_ctrl.sv
// Multi-channel kernel control sequencer. Turns the host ap_start level into
// one start pulse per enabled channel, collects per-channel done pulses and
// drives the ap_ctrl_hs / ap_ctrl_chain handshake.
// Ports:
//   ap_clk, areset   clock and synchronous active-high reset
//   ap_start         host start level; a rising edge seen in IDLE starts a run
//   ap_continue      host continue (chain mode only)
//   ap_idle/ap_done/ap_ready  block handshake outputs (registered)
//   ctrl_ch_enable   channel enable mask, captured when a run is accepted
//   ch_start         one-cycle start pulse to each enabled channel (registered)
//   ch_done          per-channel done pulses from the engines
//   run_cycles       number of LAUNCH+RUN cycles of the last completed run
module probatina_kernel_ctrl
    import probatina_ctrl_pkg::*;
#(
    parameter int unsigned C_NUM_CH     = 4,
    parameter int unsigned C_CHAIN_MODE = 0,
    parameter int unsigned C_CNT_WIDTH  = 32
) (
    input  logic                   ap_clk,
    input  logic                   areset,
    input  logic                   ap_start,
    input  logic                   ap_continue,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   ap_ready,
    input  logic [C_NUM_CH-1:0]    ctrl_ch_enable,
    output logic [C_NUM_CH-1:0]    ch_start,
    input  logic [C_NUM_CH-1:0]    ch_done,
    output logic [C_CNT_WIDTH-1:0] run_cycles
);

    ctrl_state_e            state_q, state_d;
    logic                   start_q;
    logic [C_NUM_CH-1:0]    mask_q, mask_d;
    logic [C_NUM_CH-1:0]    done_sticky_q, done_sticky_d;
    logic [C_CNT_WIDTH-1:0] run_cycles_q, run_cycles_d;
    logic                   idle_q, idle_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;
    logic [C_NUM_CH-1:0]    ch_start_q, ch_start_d;

    logic                   start_pulse;
    logic [C_NUM_CH-1:0]    done_all;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic [C_CNT_WIDTH-1:0] cnt_value;
    logic [C_CNT_WIDTH-1:0] cnt_next;

    assign start_pulse = ap_start & ~start_q;
    // Includes dones arriving this cycle so the completing pulse counts.
    assign done_all    = done_sticky_q | (ch_done & mask_q);

    probatina_sat_counter #(
        .W (C_CNT_WIDTH)
    ) u_cnt (
        .ap_clk     (ap_clk),
        .areset     (areset),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .count      (cnt_value),
        .count_next (cnt_next)
    );

    // Next-state, done aggregation and registered-output next values.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        done_sticky_d = done_sticky_q;
        run_cycles_d  = run_cycles_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    mask_d        = ctrl_ch_enable;
                    done_sticky_d = {C_NUM_CH{1'b0}};
                    cnt_clr       = 1'b1;
                    state_d       = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_en  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_en        = 1'b1;
                done_sticky_d = done_all;
                if (done_all == mask_q) begin
                    // Capture the count including this final cycle.
                    run_cycles_d = cnt_next;
                    state_d      = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (C_CHAIN_MODE == CTRL_MODE_CHAIN) begin
                    state_d = ap_continue ? ST_IDLE : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        idle_d     = (state_d == ST_IDLE);
        done_d     = (state_d == ST_DONE);
        // ap_ready fires only on entry to DONE, even if chain mode holds DONE.
        ready_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
        ch_start_d = (state_d == ST_LAUNCH) ? mask_d : {C_NUM_CH{1'b0}};
    end

    // State, captured mask/stickies and registered outputs.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            mask_q        <= {C_NUM_CH{1'b0}};
            done_sticky_q <= {C_NUM_CH{1'b0}};
            run_cycles_q  <= {C_CNT_WIDTH{1'b0}};
            idle_q        <= 1'b1;
            done_q        <= 1'b0;
            ready_q       <= 1'b0;
            ch_start_q    <= {C_NUM_CH{1'b0}};
        end else begin
            state_q       <= state_d;
            start_q       <= ap_start;
            mask_q        <= mask_d;
            done_sticky_q <= done_sticky_d;
            run_cycles_q  <= run_cycles_d;
            idle_q        <= idle_d;
            done_q        <= done_d;
            ready_q       <= ready_d;
            ch_start_q    <= ch_start_d;
        end
    end

    assign ap_idle    = idle_q;
    assign ap_done    = done_q;
    assign ap_ready   = ready_q;
    assign ch_start   = ch_start_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_probatina_kernel_ctrl.sv
// Directed bench for probatina_kernel_ctrl: one hs-mode and one chain-mode
// instance share all inputs; ap_continue is kept high except in the chain test
// so the chain instance behaves like hs elsewhere.
module tb_probatina_kernel_ctrl;

    logic        ap_clk      = 1'b0;
    logic        areset      = 1'b1;
    logic        ap_start    = 1'b0;
    logic        ap_continue = 1'b1;
    logic [3:0]  en          = 4'd0;
    logic [3:0]  ch_done     = 4'd0;

    logic        hs_idle, hs_done, hs_ready;
    logic [3:0]  hs_ch_start;
    logic [31:0] hs_run;
    logic        cm_idle, cm_done, cm_ready;
    logic [3:0]  cm_ch_start;
    logic [31:0] cm_run;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    probatina_kernel_ctrl #(.C_NUM_CH(4), .C_CHAIN_MODE(0), .C_CNT_WIDTH(32)) u_hs (
        .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(hs_idle), .ap_done(hs_done), .ap_ready(hs_ready),
        .ctrl_ch_enable(en), .ch_start(hs_ch_start), .ch_done(ch_done), .run_cycles(hs_run)
    );

    probatina_kernel_ctrl #(.C_NUM_CH(4), .C_CHAIN_MODE(1), .C_CNT_WIDTH(32)) u_cm (
        .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(cm_idle), .ap_done(cm_done), .ap_ready(cm_ready),
        .ctrl_ch_enable(en), .ch_start(cm_ch_start), .ch_done(ch_done), .run_cycles(cm_run)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        ch_done = m;
        tick();
        ch_done = 4'd0;
    endtask

    // Raise ap_start for one cycle; returns in the LAUNCH cycle with cyc=0.
    task automatic start(input logic [3:0] m);
        ap_start = 1'b1;
        en       = m;
        tick();
        cyc      = 0;
        ap_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_idle", hs_idle, 1'b1);
        chk("rst_done", hs_done, 1'b0);
        chk("rst_ready", hs_ready, 1'b0);
        chk("rst_ch_start", hs_ch_start, 4'd0);
        chk("rst_run", hs_run, 32'd0);
        chk("rst_cm_idle", cm_idle, 1'b1);
        areset = 1'b0;
        tick();

        // Test 1: full mask, dones at +5,+7,+9,+12
        start(4'hF);
        chk("t1_ch_start", hs_ch_start, 4'hF);
        chk("t1_idle_drop", hs_idle, 1'b0);
        tick();
        chk("t1_ch_start_pulse", hs_ch_start, 4'h0);
        goto(5);  pulse(4'h1);
        goto(7);  pulse(4'h2);
        goto(9);  pulse(4'h4);
        goto(12);
        chk("t1_not_done_yet", hs_done, 1'b0);
        pulse(4'h8);
        chk("t1_done", hs_done, 1'b1);
        chk("t1_ready", hs_ready, 1'b1);
        chk("t1_cm_done", cm_done, 1'b1);
        tick();
        chk("t1_done_fall", hs_done, 1'b0);
        chk("t1_ready_fall", hs_ready, 1'b0);
        chk("t1_idle", hs_idle, 1'b1);
        chk("t1_run", hs_run, 32'd13);
        chk("t1_cm_run", cm_run, 32'd13);

        // Test 2: mask 0101, disabled-channel dones ignored
        tick();
        start(4'h5);
        chk("t2_ch_start", hs_ch_start, 4'h5);
        goto(3); pulse(4'hA);
        goto(8);
        chk("t2_no_done", hs_done, 1'b0);
        pulse(4'h5);
        chk("t2_done", hs_done, 1'b1);
        tick();
        chk("t2_run", hs_run, 32'd9);

        // Test 3: chain mode, ap_continue held low for 10 cycles
        tick();
        ap_continue = 1'b0;
        start(4'h3);
        goto(2); pulse(4'h3);
        for (int k = 0; k < 10; k++) begin
            chk("t3_cm_done_held", cm_done, 1'b1);
            chk("t3_cm_ready", cm_ready, (k == 0) ? 1'b1 : 1'b0);
            chk("t3_cm_idle_low", cm_idle, 1'b0);
            if (k == 1) chk("t3_hs_idle", hs_idle, 1'b1);
            if (k == 9) ap_continue = 1'b1;
            tick();
        end
        chk("t3_cm_idle", cm_idle, 1'b1);
        chk("t3_cm_done_fall", cm_done, 1'b0);
        chk("t3_cm_run", cm_run, 32'd3);

        // Test 4: start edge during RUN is dropped, held level does not restart
        tick();
        start(4'hF);
        goto(3); ap_start = 1'b1;
        goto(4); pulse(4'hF);
        chk("t4_done", hs_done, 1'b1);
        chk("t4_run", hs_run, 32'd5);
        goto(8);
        chk("t4_idle_held", hs_idle, 1'b1);
        chk("t4_no_restart", hs_ch_start, 4'h0);
        chk("t4_no_done", hs_done, 1'b0);
        ap_start = 1'b0;
        tick();
        start(4'hF);
        chk("t4_run2_start", hs_ch_start, 4'hF);
        tick(); pulse(4'hF);
        chk("t4_run2_done", hs_done, 1'b1);
        chk("t4_run2_cycles", hs_run, 32'd2);

        // Test 5: dones in IDLE ignored, then empty mask
        tick(); tick();
        pulse(4'hF);
        chk("t5_idle_done_ignored", hs_done, 1'b0);
        start(4'h0);
        chk("t5_ch_start", hs_ch_start, 4'h0);
        chk("t5_idle_drop", hs_idle, 1'b0);
        tick();
        chk("t5_not_done", hs_done, 1'b0);
        tick();
        chk("t5_done", hs_done, 1'b1);
        chk("t5_run", hs_run, 32'd2);

        // Test 6: reset mid-run with stickies 0011, then fresh run
        tick(); tick();
        start(4'hF);
        goto(2); pulse(4'h3);
        areset = 1'b1;
        tick();
        chk("t6_rst_idle", hs_idle, 1'b1);
        chk("t6_rst_run", hs_run, 32'd0);
        areset = 1'b0;
        tick();
        start(4'hF);
        goto(2); pulse(4'h4);
        goto(4); pulse(4'h8);
        chk("t6_no_stale_done", hs_done, 1'b0);
        goto(6); pulse(4'h1);
        goto(8);
        chk("t6_still_waiting", hs_done, 1'b0);
        pulse(4'h2);
        chk("t6_done", hs_done, 1'b1);

        // Reset in the start-pulse cycle suppresses ch_start
        tick(); tick();
        ap_start = 1'b1;
        en       = 4'hF;
        areset   = 1'b1;
        tick();
        chk("t7_ch_start_suppressed", hs_ch_start, 4'h0);
        chk("t7_idle", hs_idle, 1'b1);
        areset   = 1'b0;
        ap_start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
